// File: rtl/route_pkg.sv
// Shared types and constants for the route requester.
// Holds the FSM state enum, result status codes and default widths.
package route_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [1:0] ST_GRANT   = 2'b00;
    localparam logic [1:0] ST_DENY    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam int DESC_W_DEF = 30;

endpackage

// File: rtl/route_backoff_ctr.sv
// Loadable down-counter timing the pause between route re-requests.
// Ports: clk, rst_n, load, load_val[W], dec in; done out (count == 1).
module route_backoff_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    // The requester leaves backoff in the cycle after the count reads 1.
    assign done = (count == W'(1));

endmodule

// File: rtl/route_requester.sv
// Requests a route for each upstream descriptor, retrying with binary
// exponential backoff on deny, and reports grant/deny/timeout downstream.
// Ports: clk, rst_n; in_valid/in_ready/in_desc upstream; rt_req/rt_desc
// to router, rt_grant/rt_deny from router; out_valid/out_ready/
// out_status/out_retries downstream.
// Optional: ROUTE_REQUESTER_TIMEOUT_EN adds a per-request wait timeout.
module route_requester
    import route_pkg::*;
#(
    parameter int DESC_W    = DESC_W_DEF,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DESC_W-1:0] in_desc,
    output logic              rt_req,
    output logic [DESC_W-1:0] rt_desc,
    input  logic              rt_grant,
    input  logic              rt_deny,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_status,
    output logic [1:0]        out_retries
);

    // Longest backoff is 2^(MAX_RETRY-1); one spare bit keeps it exact.
    localparam int         CNT_W  = MAX_RETRY + 1;
    localparam logic [1:0] MAX_RC = 2'(MAX_RETRY);

    state_t           state;
    logic [1:0]       rcnt;
    logic             retry_ok;
    logic             bo_load;
    logic             bo_dec;
    logic             bo_done;
    logic [CNT_W-1:0] bo_val;
    logic             enter_req;
    logic             timed_out;

    assign retry_ok  = (rcnt < MAX_RC);
    // Grant wins over a simultaneous deny, so only a lone deny backs off.
    assign bo_load   = (state == S_REQ) && !rt_grant && rt_deny && retry_ok;
    assign bo_dec    = (state == S_BACKOFF) && !bo_done;
    assign bo_val    = CNT_W'(1) << rcnt;
    assign enter_req = ((state == S_IDLE) && in_valid)
                     || ((state == S_BACKOFF) && bo_done);

    route_backoff_ctr #(
        .W (CNT_W)
    ) u_backoff (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bo_load),
        .load_val (bo_val),
        .dec      (bo_dec),
        .done     (bo_done)
    );

`ifdef ROUTE_REQUESTER_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT + 1);

    logic [WC_W-1:0] wcnt;

    // Counts REQ cycles since the latest (re)entry into REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (enter_req) begin
            wcnt <= '0;
        end else if (state == S_REQ) begin
            wcnt <= wcnt + WC_W'(1);
        end
    end

    assign timed_out = (state == S_REQ) && (wcnt == WC_W'(TIMEOUT - 1));
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;

    logic enter_req_unused;

    assign enter_req_unused = enter_req;
    assign timed_out        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            rt_req      <= 1'b0;
            rt_desc     <= '0;
            out_valid   <= 1'b0;
            out_status  <= ST_GRANT;
            out_retries <= 2'd0;
            rcnt        <= 2'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state    <= S_REQ;
                        in_ready <= 1'b0;
                        rt_req   <= 1'b1;
                        rt_desc  <= in_desc;
                        rcnt     <= 2'd0;
                    end
                end
                S_REQ: begin
                    if (rt_grant) begin
                        state       <= S_RESP;
                        rt_req      <= 1'b0;
                        out_valid   <= 1'b1;
                        out_status  <= ST_GRANT;
                        out_retries <= rcnt;
                    end else if (rt_deny) begin
                        rt_req <= 1'b0;
                        if (retry_ok) begin
                            state <= S_BACKOFF;
                            rcnt  <= rcnt + 2'd1;
                        end else begin
                            state       <= S_RESP;
                            out_valid   <= 1'b1;
                            out_status  <= ST_DENY;
                            out_retries <= rcnt;
                        end
                    end else if (timed_out) begin
                        state       <= S_RESP;
                        rt_req      <= 1'b0;
                        out_valid   <= 1'b1;
                        out_status  <= ST_TIMEOUT;
                        out_retries <= rcnt;
                    end
                end
                S_BACKOFF: begin
                    if (bo_done) begin
                        state  <= S_REQ;
                        rt_req <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_requester.sv
// Directed self-checking bench for route_requester.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_route_requester;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_desc;
    logic        rt_req;
    logic [29:0] rt_desc;
    logic        rt_grant;
    logic        rt_deny;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_status;
    logic [1:0]  out_retries;

    int n_cmp;
    int n_fail;

    route_requester dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_desc     (in_desc),
        .rt_req      (rt_req),
        .rt_desc     (rt_desc),
        .rt_grant    (rt_grant),
        .rt_deny     (rt_deny),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_status  (out_status),
        .out_retries (out_retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [29:0] d);
        in_valid = 1'b1;
        in_desc  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (rt_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rt_req: got %b expected 0", rt_req);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if (rt_desc !== 30'h0) begin
            n_fail++;
            $display("FAIL rst_rt_desc: got %h expected 0", rt_desc);
        end
        n_cmp++;
        if (out_status !== 2'b00 || out_retries !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_status: got %b/%0d expected 00/0",
                     out_status, out_retries);
        end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b expected 1", in_ready);
        end
        // A grant outside REQ must be ignored.
        rt_grant = 1'b1;
        tick();
        rt_grant = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_grant_ignored: got ov=%b ir=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_immediate_grant();
        start(30'h2AAAAAAA);
        in_desc = 30'h11111111;
        n_cmp++;
        if (rt_req !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ig_req: got req=%b ir=%b expected 1/0",
                     rt_req, in_ready);
        end
        n_cmp++;
        if (rt_desc !== 30'h2AAAAAAA) begin
            n_fail++;
            $display("FAIL ig_desc: got %h expected 2aaaaaaa", rt_desc);
        end
        rt_grant = 1'b1;
        tick();
        rt_grant = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || rt_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ig_out: got ov=%b req=%b expected 1/0",
                     out_valid, rt_req);
        end
        n_cmp++;
        if (out_status !== 2'b00 || out_retries !== 2'd0) begin
            n_fail++;
            $display("FAIL ig_status: got %b/%0d expected 00/0",
                     out_status, out_retries);
        end
        n_cmp++;
        if (rt_desc !== 30'h2AAAAAAA) begin
            n_fail++;
            $display("FAIL ig_desc_held: got %h expected 2aaaaaaa", rt_desc);
        end
        release_out();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ig_release: got ov=%b ir=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_deny_deny_grant();
        int gap;
        int exp_gap [2] = '{1, 2};
        start(30'h0000_1234);
        for (int i = 0; i < 2; i++) begin
            rt_deny = 1'b1;
            tick();
            rt_deny = 1'b0;
            gap = 0;
            while (!rt_req && gap < 50) begin
                gap++;
                tick();
            end
            n_cmp++;
            if (gap !== exp_gap[i]) begin
                n_fail++;
                $display("FAIL ddg_gap%0d: got %0d expected %0d",
                         i, gap, exp_gap[i]);
            end
        end
        rt_grant = 1'b1;
        tick();
        rt_grant = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_status !== 2'b00
            || out_retries !== 2'd2) begin
            n_fail++;
            $display("FAIL ddg_result: got ov=%b %b/%0d expected 1 00/2",
                     out_valid, out_status, out_retries);
        end
        release_out();
    endtask

    task automatic test_retry_exhaust();
        int gap;
        int exp_gap [3] = '{1, 2, 4};
        start(30'h0ABC_DEF0);
        for (int i = 0; i < 3; i++) begin
            rt_deny = 1'b1;
            tick();
            rt_deny = 1'b0;
            gap = 0;
            while (!rt_req && gap < 50) begin
                gap++;
                tick();
            end
            n_cmp++;
            if (gap !== exp_gap[i]) begin
                n_fail++;
                $display("FAIL rx_gap%0d: got %0d expected %0d",
                         i, gap, exp_gap[i]);
            end
        end
        rt_deny = 1'b1;
        tick();
        rt_deny = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || rt_req !== 1'b0 || out_status !== 2'b01
            || out_retries !== 2'd3) begin
            n_fail++;
            $display("FAIL rx_result: got ov=%b req=%b %b/%0d expected 1 0 01/3",
                     out_valid, rt_req, out_status, out_retries);
        end
        release_out();
    endtask

    task automatic test_grant_and_deny();
        start(30'h0000_0055);
        rt_grant = 1'b1;
        rt_deny  = 1'b1;
        tick();
        rt_grant = 1'b0;
        rt_deny  = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_status !== 2'b00
            || out_retries !== 2'd0) begin
            n_fail++;
            $display("FAIL gd_result: got ov=%b %b/%0d expected 1 00/0",
                     out_valid, out_status, out_retries);
        end
        release_out();
    endtask

    task automatic test_timeout();
        int hi;
        start(30'h0000_0777);
`ifdef ROUTE_REQUESTER_TIMEOUT_EN
        hi = 0;
        while (rt_req && hi < 100) begin
            hi++;
            tick();
        end
        n_cmp++;
        if (hi !== 15) begin
            n_fail++;
            $display("FAIL to_req_cycles: got %0d expected 15", hi);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_status !== 2'b10) begin
            n_fail++;
            $display("FAIL to_result: got ov=%b st=%b expected 1/10",
                     out_valid, out_status);
        end
`else
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        n_cmp++;
        if (rt_req !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nto_wait: got req=%b ov=%b expected 1/0",
                     rt_req, out_valid);
        end
        rt_grant = 1'b1;
        tick();
        rt_grant = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_status !== 2'b00) begin
            n_fail++;
            $display("FAIL nto_result: got ov=%b st=%b expected 1/00",
                     out_valid, out_status);
        end
`endif
        release_out();
    endtask

    task automatic test_backpressure();
        logic held_ok;
        start(30'h0000_0ABC);
        rt_deny = 1'b1;
        tick();
        rt_deny = 1'b0;
        tick();
        rt_grant = 1'b1;
        tick();
        rt_grant = 1'b0;
        held_ok  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rt_deny = (i == 2);
            tick();
            if (out_valid !== 1'b1 || out_status !== 2'b00
                || out_retries !== 2'd1 || in_ready !== 1'b0) begin
                held_ok = 1'b0;
            end
        end
        rt_deny  = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_held: last ov=%b %b/%0d ir=%b expected 1 00/1 0",
                     out_valid, out_status, out_retries, in_ready);
        end
        release_out();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || rt_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b req=%b expected 0 1 0",
                     out_valid, in_ready, rt_req);
        end
    endtask

    task automatic test_reset_in_backoff();
        logic quiet;
        start(30'h0000_0F0F);
        rt_deny = 1'b1;
        tick();
        rt_deny = 1'b0;
        tick();
        rt_deny = 1'b1;
        tick();
        rt_deny = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rt_req !== 1'b0 || out_valid !== 1'b0 || rt_desc !== 30'h0) begin
            n_fail++;
            $display("FAIL rb_async: got req=%b ov=%b desc=%h expected 0 0 0",
                     rt_req, out_valid, rt_desc);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || rt_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_after: got ir=%b req=%b ov=%b expected 1 0 0",
                     in_ready, rt_req, out_valid);
        end
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0 || rt_req !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL rb_silent: got ov=%b req=%b expected 0 0",
                     out_valid, rt_req);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_desc   = '0;
        rt_grant  = 1'b0;
        rt_deny   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_immediate_grant();
        test_deny_deny_grant();
        test_retry_exhaust();
        test_grant_and_deny();
        test_timeout();
        test_backpressure();
        test_reset_in_backoff();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
